// File: rtl/decomp_dict.sv
// decomp_dict: dual-bank circular dictionary mirroring the compressor, with two
// registered lookup ports reporting data and never-written (miss) status.
module decomp_dict #(
  parameter int DATA_WIDTH  = 32,
  parameter int SIZE        = 8,
  parameter int TOTAL_WORDS = 16,
  localparam int IW = $clog2(TOTAL_WORDS),
  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clr,
  input  logic                  wr,
  input  logic                  wr2,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [DATA_WIDTH-1:0] w_data2,
  input  logic                  rd_en,
  input  logic [IW-1:0]         rd_idx,
  input  logic                  rd_en2,
  input  logic [IW-1:0]         rd_idx2,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [DATA_WIDTH-1:0] o_rd_data2,
  output logic                  o_rd_valid,
  output logic                  o_rd_valid2,
  output logic                  o_rd_miss,
  output logic                  o_rd_miss2,
  output logic [AW-1:0]         wr_addr,
  output logic                  full
);
  logic [DATA_WIDTH-1:0]  mem_q [TOTAL_WORDS];
  logic [TOTAL_WORDS-1:0] written_q;
  logic [AW-1:0]          ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]  data_q, data2_q;
  logic                   valid_q, valid2_q, miss_q, miss2_q;
  logic [IW-1:0]          idx1, idx2;
  // Flattened order {bank2[k], bank1[k]}: bank 1 at even entries, bank 2 at odd.
  assign idx1 = IW'({ptr_q, 1'b0});
  assign idx2 = IW'({ptr_q, 1'b1});
  always_comb ptr_d = (wr | wr2) ? ((ptr_q == AW'(SIZE - 1)) ? '0 : ptr_q + 1'b1) : ptr_q;
  always_ff @(posedge i_clk) begin
    if (i_reset | i_clr) begin
      mem_q     <= '{default: '0};
      written_q <= '0;
      ptr_q     <= '0;
      data_q    <= '0;
      data2_q   <= '0;
      valid_q   <= 1'b0;
      valid2_q  <= 1'b0;
      miss_q    <= 1'b0;
      miss2_q   <= 1'b0;
    end else begin
      // Lookups sample pre-write contents, matching the compressor's compare.
      valid_q  <= rd_en;
      valid2_q <= rd_en2;
      if (rd_en) begin
        data_q <= mem_q[rd_idx];
        miss_q <= ~written_q[rd_idx];
      end
      if (rd_en2) begin
        data2_q <= mem_q[rd_idx2];
        miss2_q <= ~written_q[rd_idx2];
      end
      if (wr) begin
        mem_q[idx1]     <= w_data;
        written_q[idx1] <= 1'b1;
      end
      if (wr2) begin
        mem_q[idx2]     <= w_data2;
        written_q[idx2] <= 1'b1;
      end
      ptr_q <= ptr_d;
    end
  end
  assign o_rd_data   = data_q;
  assign o_rd_data2  = data2_q;
  assign o_rd_valid  = valid_q;
  assign o_rd_valid2 = valid2_q;
  assign o_rd_miss   = miss_q;
  assign o_rd_miss2  = miss2_q;
  assign wr_addr     = ptr_q;
  assign full        = ptr_q == AW'(SIZE - 1);
endmodule

// File: tb/tb_decomp_dict.sv
// tb_decomp_dict: directed plus randomized stimulus checked every cycle against
// a flat-array model of the dictionary, with literal spot checks pinning the model.
module tb_decomp_dict;
  localparam int DW = 32, SIZE = 8, TW = 16;
  logic i_clk = 0, i_reset = 0, i_clr = 0, wr = 0, wr2 = 0, rd_en = 0, rd_en2 = 0;
  logic [DW-1:0] w_data = 0, w_data2 = 0;
  logic [3:0] rd_idx = 0, rd_idx2 = 0;
  logic [DW-1:0] o_rd_data, o_rd_data2;
  logic o_rd_valid, o_rd_valid2, o_rd_miss, o_rd_miss2, full;
  logic [2:0] wr_addr;
  int n_cmp = 0, n_bad = 0;
  bit chk = 0;

  decomp_dict #(.DATA_WIDTH(DW), .SIZE(SIZE), .TOTAL_WORDS(TW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_clr(i_clr), .wr(wr), .wr2(wr2),
    .w_data(w_data), .w_data2(w_data2), .rd_en(rd_en), .rd_idx(rd_idx),
    .rd_en2(rd_en2), .rd_idx2(rd_idx2), .o_rd_data(o_rd_data), .o_rd_data2(o_rd_data2),
    .o_rd_valid(o_rd_valid), .o_rd_valid2(o_rd_valid2), .o_rd_miss(o_rd_miss),
    .o_rd_miss2(o_rd_miss2), .wr_addr(wr_addr), .full(full));

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Reference model: entries as a flat array indexed 2*row+bank.
  logic [DW-1:0] m_mem [TW];
  bit m_wrt [TW];
  int m_ptr = 0;
  logic [DW-1:0] e_d = 0, e_d2 = 0;
  bit e_v = 0, e_v2 = 0, e_m = 0, e_m2 = 0;

  always @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      for (int k = 0; k < TW; k++) begin m_mem[k] = 0; m_wrt[k] = 0; end
      m_ptr = 0; e_v = 0; e_v2 = 0; e_m = 0; e_m2 = 0; e_d = 0; e_d2 = 0;
    end else begin
      e_v = rd_en; e_v2 = rd_en2;
      if (rd_en) begin e_d = m_mem[rd_idx]; e_m = !m_wrt[rd_idx]; end
      if (rd_en2) begin e_d2 = m_mem[rd_idx2]; e_m2 = !m_wrt[rd_idx2]; end
      if (wr) begin m_mem[2*m_ptr] = w_data; m_wrt[2*m_ptr] = 1; end
      if (wr2) begin m_mem[2*m_ptr+1] = w_data2; m_wrt[2*m_ptr+1] = 1; end
      if (wr || wr2) m_ptr = (m_ptr + 1) % SIZE;
    end
  end

  always @(negedge i_clk) if (chk) begin
    check("valid", o_rd_valid, e_v);
    check("valid2", o_rd_valid2, e_v2);
    check("data", o_rd_data, e_d);
    check("data2", o_rd_data2, e_d2);
    check("miss", o_rd_miss, e_m);
    check("miss2", o_rd_miss2, e_m2);
    check("wr_addr", wr_addr, m_ptr);
    check("full", full, m_ptr == SIZE - 1);
  end

  task automatic cyc();
    @(posedge i_clk);
    @(negedge i_clk);
    {i_reset, i_clr, wr, wr2, rd_en, rd_en2} = 0;
  endtask

  task automatic rd(input int a, input int b);
    rd_en = 1; rd_idx = 4'(a); rd_en2 = 1; rd_idx2 = 4'(b);
  endtask

  initial begin
    logic [DW-1:0] held;
    @(negedge i_clk);
    i_reset = 1; cyc();
    chk = 1;
    i_reset = 1; cyc();
    check("rst_valid", o_rd_valid, 0);
    check("rst_data", o_rd_data, 0);
    // Lookup after reset misses with zero data
    rd_en = 1; rd_idx = 5; cyc();
    check("t1_valid", o_rd_valid, 1);
    check("t1_miss", o_rd_miss, 1);
    check("t1_data", o_rd_data, 0);
    check("t1_ptr", wr_addr, 0);
    check("t1_full", full, 0);
    // Single-bank writes
    wr = 1; w_data = 32'hAAAA0001; cyc();
    wr2 = 1; w_data2 = 32'hBBBB0002; cyc();
    rd(0, 3); cyc();
    check("t2_d0", o_rd_data, 32'hAAAA0001);
    check("t2_d3", o_rd_data2, 32'hBBBB0002);
    check("t2_m", o_rd_miss | o_rd_miss2, 0);
    rd(3, 0); cyc();
    check("t2_d3a", o_rd_data, 32'hBBBB0002);
    check("t2_d0b", o_rd_data2, 32'hAAAA0001);
    rd(1, 1); cyc();
    check("t2_miss1", o_rd_miss, 1);
    check("t2_ptr", wr_addr, 2);
    // Wrap-around from a fresh dictionary
    i_clr = 1; cyc();
    for (int i = 0; i < 10; i++) begin
      wr = 1; wr2 = 1; w_data = DW'(i); w_data2 = DW'(32'h100 + i); cyc();
      if (i == 6) begin check("t3_ptr7", wr_addr, 7); check("t3_full", full, 1); end
      if (i == 7) check("t3_wrap", wr_addr, 0);
    end
    check("t3_ptr", wr_addr, 2);
    rd(0, 1); cyc();
    check("t3_d0", o_rd_data, 8);
    check("t3_d1", o_rd_data2, 32'h108);
    rd(4, 4); cyc();
    check("t3_d4", o_rd_data, 2);
    check("t3_d4b", o_rd_data2, 2);
    // Same-cycle write/read returns pre-write contents
    i_clr = 1; cyc();
    for (int i = 0; i < 3; i++) begin wr2 = 1; w_data2 = DW'(32'h50 + i); cyc(); end
    wr = 1; w_data = 32'hDEAD; rd_en = 1; rd_idx = 6; cyc();
    check("t4_old", o_rd_data, 0);
    check("t4_oldm", o_rd_miss, 1);
    rd_en = 1; rd_idx = 6; cyc();
    check("t4_new", o_rd_data, 32'hDEAD);
    check("t4_newm", o_rd_miss, 0);
    // Clear while a read is requested
    rd(6, 5); i_clr = 1; cyc();
    check("t5_valid", o_rd_valid, 0);
    check("t5_ptr", wr_addr, 0);
    for (int i = 0; i < TW; i += 2) begin rd(i, i + 1); cyc(); end
    check("t5_miss", o_rd_miss, 1);
    check("t5_data", o_rd_data2, 0);
    // Idle: outputs hold
    wr = 1; w_data = 32'h1234; cyc();
    rd_en = 1; rd_idx = 0; cyc();
    held = o_rd_data;
    check("t6_d", held, 32'h1234);
    repeat (4) cyc();
    check("t6_hold", o_rd_data, 32'h1234);
    check("t6_valid", o_rd_valid, 0);
    check("t6_ptr", wr_addr, 1);
    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      wr = 1'($urandom_range(0, 2) == 0); wr2 = 1'($urandom_range(0, 2) == 0);
      w_data = $urandom; w_data2 = $urandom;
      rd_en = 1'($urandom); rd_idx = 4'($urandom); rd_en2 = 1'($urandom); rd_idx2 = 4'($urandom);
      i_clr = $urandom_range(0, 59) == 0; i_reset = $urandom_range(0, 149) == 0;
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
